// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, N data bits LSB first, optional parity, stop bit(s).
// Bit timing comes from a shared 16x oversampling tick; all outputs are registered.
module uart_transmitter #(
    parameter int N       = 8,
    parameter int PARITY  = 0,
    parameter int SB_TICK = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_tick,
    input  logic         tx_start,
    input  logic [N-1:0] din,
    output logic         tx,
    output logic         tx_busy,
    output logic         tx_done
);

    localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int BW = $clog2(N);

    localparam logic [TW-1:0] BIT_LAST  = TW'(15);
    localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(N - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [N-1:0]  shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    shift_d = din;
                    par_d   = (PARITY == 2) ? ~(^din) : ^din;
                    tick_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (sample_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (sample_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == DATA_LAST) begin
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (sample_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        state_d = S_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            S_STOP: begin
                if (sample_tick) begin
                    if (tick_q == STOP_LAST) begin
                        tick_d  = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level is decoded from the next state so tx changes on the same edge as the state.
    always_comb begin
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: four instances covering no/even/odd parity and a
// two-stop-bit build with the sample tick tied high.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick4 = 1'b0;
    logic       tick_hi;
    logic [3:0] start_r;
    logic [7:0] din;
    logic [3:0] tx_w, busy_w, done_w;
    int         total = 0;
    int         bad = 0;
    int         tdiv = 0;

    always #5 clk = ~clk;

    // Tick every 4th clock, updated just after the rising edge so it is stable at the next one.
    initial forever begin
        @(posedge clk);
        #2;
        tdiv  = (tdiv + 1) % 4;
        tick4 = (tdiv == 0);
    end

    uart_transmitter #(.N(8), .PARITY(0), .SB_TICK(16)) u_none (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick4), .tx_start(start_r[0]), .din(din),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_transmitter #(.N(8), .PARITY(1), .SB_TICK(16)) u_even (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick4), .tx_start(start_r[1]), .din(din),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_transmitter #(.N(8), .PARITY(2), .SB_TICK(16)) u_odd (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick4), .tx_start(start_r[2]), .din(din),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_transmitter #(.N(8), .PARITY(0), .SB_TICK(32)) u_sb32 (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick_hi), .tx_start(start_r[3]), .din(din),
        .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge where tick4 will be sampled high.
    task automatic align4();
        for (int i = 0; i < 8 && tick4 !== 1'b1; i++) @(negedge clk);
    endtask

    // Pulse tx_start for one clock; returns on the falling edge right after the accepting edge.
    task automatic launch(input int d, input logic [7:0] data);
        if (d < 3) align4();
        din        = data;
        start_r[d] = 1'b1;
        @(negedge clk);
        start_r[d] = 1'b0;
    endtask

    // Cycle 0 is the falling edge after acceptance. Samples each bit mid-way, records the
    // cycle of the first tx_done, and returns on that cycle's falling edge.
    task automatic observe(input int d, input int nb, input int cpb, input int exp_done,
                           input logic [15:0] exp_bits, input string tag, input int inject);
        logic [15:0] got = '0;
        int          done_cyc = -1;
        bit          busy_ok = 1'b1;
        int          k = 0;
        for (int cyc = 0; cyc <= exp_done + 50; cyc++) begin
            if (cyc == inject) begin
                start_r[d] = 1'b1;
                din        = 8'hFF;
            end
            if (cyc == inject + 1) start_r[d] = 1'b0;
            if (k < nb && cyc == k * cpb + cpb / 2) begin
                got[k] = tx_w[d];
                k++;
            end
            if (done_w[d] === 1'b1) begin
                done_cyc = cyc;
                if (busy_w[d] !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy_w[d] !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
        end
        check({tag, ".bits"}, 32'(got), 32'(exp_bits));
        check({tag, ".done_cycle"}, done_cyc, exp_done);
        check({tag, ".busy"}, 32'(busy_ok), 32'd1);
        check({tag, ".tx_idle"}, 32'(tx_w[d]), 32'd1);
    endtask

    initial begin
        int cnt;
        bit flag;
        rst_n   = 1'b0;
        start_r = '0;
        din     = '0;
        tick_hi = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.tx", 32'(tx_w), 32'hF);
        check("reset.busy", 32'(busy_w), 32'h0);
        check("reset.done", 32'(done_w), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1 ; 160 ticks * 4 clks
        launch(0, 8'hA5);
        observe(0, 10, 64, 640, 16'h034A, "none_a5", -10);

        // Parity: even(A5)=0, odd(A5)=1, even(07)=1 ; 176 ticks * 4 clks
        launch(1, 8'hA5);
        observe(1, 11, 64, 704, 16'h054A, "even_a5", -10);
        launch(2, 8'hA5);
        observe(2, 11, 64, 704, 16'h074A, "odd_a5", -10);
        launch(1, 8'h07);
        observe(1, 11, 64, 704, 16'h060E, "even_07", -10);

        // Re-pulse with din=0xFF during DATA must not disturb the frame in flight
        launch(0, 8'hA5);
        observe(0, 10, 64, 640, 16'h034A, "ignore", 200);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done_w[0] === 1'b1) cnt++;
        end
        check("ignore.extra_done", cnt, 0);

        // Back-to-back with tx_start held; next word presented in the tx_done cycle
        align4();
        din        = 8'h3C;
        start_r[0] = 1'b1;
        @(negedge clk);
        observe(0, 10, 64, 640, 16'h0278, "b2b1", -10);
        din = 8'hC3;
        @(negedge clk);
        start_r[0] = 1'b0;
        check("b2b.start_bit", 32'(tx_w[0]), 32'd0);
        check("b2b.busy", 32'(busy_w[0]), 32'd1);
        observe(0, 10, 64, 639, 16'h0386, "b2b2", -10);

        // Two stop bits, tick tied high: done 16*9+32 clks after acceptance
        launch(3, 8'h3C);
        observe(3, 10, 16, 176, 16'h0278, "sb32", -10);

        // Asynchronous reset in the middle of a 0 data bit
        launch(0, 8'hA5);
        repeat (150) @(negedge clk);
        check("rst_mid.pre_tx", 32'(tx_w[0]), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid.tx", 32'(tx_w[0]), 32'd1);
        check("rst_mid.busy", 32'(busy_w[0]), 32'd0);
        check("rst_mid.done", 32'(done_w[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt  = 0;
        flag = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (done_w[0] === 1'b1) cnt++;
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) flag = 1'b0;
        end
        check("rst_mid.no_done", cnt, 0);
        check("rst_mid.idle", 32'(flag), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
